// File: rtl/seq_rec_pattern_shft_reg_if.sv
// Serial-stream bundle for the shift-register pattern recognizer.
// The producer drives data/enable/clear; the recognizer returns the match flag and count.
interface seq_rec_pattern_shft_reg_if #(
    parameter int CNT_W = 8
);
    logic             D_in;
    logic             En;
    logic             clr_cnt;
    logic             D_out;
    logic [CNT_W-1:0] match_cnt;

    modport master (output D_in, output En, output clr_cnt, input D_out, input match_cnt);
    modport slave  (input D_in, input En, input clr_cnt, output D_out, output match_cnt);
endinterface

// File: rtl/seq_rec_pattern_shft_reg.sv
// Parametrised N-bit serial pattern recognizer (Mealy/Moore, overlap/non-overlap), falling-edge state.
// Optional saturating match counter compiled in when SEQ_REC_MATCH_CNT_EN is defined.
module seq_rec_pattern_shft_reg #(
    parameter int             N       = 3,
    parameter logic [N-1:0]   PATTERN = 3'b111,
    parameter bit             MOORE   = 1'b0,
    parameter bit             OVERLAP = 1'b1,
    parameter int             CNT_W   = 8
) (
    input  logic                        clk,
    input  logic                        reset,
    seq_rec_pattern_shft_reg_if.slave   bus
);
    localparam int FW = $clog2(N + 1);

    logic [N-1:0]  data_reg, data_next;
    logic [FW-1:0] fill_reg, fill_next;
    logic [N-1:0]  shifted;
    logic [FW-1:0] fill_inc;
    logic          mealy_hit;
    logic          moore_now;
    logic          match_event;

    assign shifted  = {data_reg[N-2:0], bus.D_in};
    assign fill_inc = (fill_reg == FW'(N)) ? fill_reg : fill_reg + FW'(1);

    // The fill guard keeps reset zeros in Data from matching a zero-bearing pattern.
    assign mealy_hit = bus.En && (fill_reg >= FW'(N - 1)) &&
                       (data_reg[N-2:0] == PATTERN[N-1:1]) && (bus.D_in == PATTERN[0]);
    assign moore_now = (fill_reg == FW'(N)) && (data_reg == PATTERN);

    always_comb begin
        data_next   = data_reg;
        fill_next   = fill_reg;
        match_event = 1'b0;
        if (bus.En) begin
            if (!MOORE) begin
                match_event = mealy_hit;
                if (mealy_hit && !OVERLAP) begin
                    data_next = '0;
                    fill_next = '0;
                end else begin
                    data_next = shifted;
                    fill_next = fill_inc;
                end
            end else begin
                // Non-overlapping Moore drops the matched bits at the consume after the match.
                if (!OVERLAP && moore_now) begin
                    data_next = {{(N-1){1'b0}}, bus.D_in};
                    fill_next = FW'(1);
                end else begin
                    data_next = shifted;
                    fill_next = fill_inc;
                end
                match_event = (fill_next == FW'(N)) && (data_next == PATTERN);
            end
        end
    end

    always_ff @(negedge clk or negedge reset) begin
        if (!reset) begin
            data_reg <= '0;
            fill_reg <= '0;
        end else begin
            data_reg <= data_next;
            fill_reg <= fill_next;
        end
    end

    generate
        if (MOORE) begin : g_moore_out
            assign bus.D_out = moore_now;
        end else begin : g_mealy_out
            assign bus.D_out = mealy_hit;
        end
    endgenerate

`ifdef SEQ_REC_MATCH_CNT_EN
    logic [CNT_W-1:0] cnt_reg;

    always_ff @(negedge clk or negedge reset) begin
        if (!reset) begin
            cnt_reg <= '0;
        end else if (bus.clr_cnt) begin
            cnt_reg <= '0;
        end else if (match_event && (cnt_reg != {CNT_W{1'b1}})) begin
            cnt_reg <= cnt_reg + CNT_W'(1);
        end
    end

    assign bus.match_cnt = cnt_reg;
`else
    logic unused_cnt_inputs;
    assign unused_cnt_inputs = ^{match_event, bus.clr_cnt};
    assign bus.match_cnt     = '0;
`endif

endmodule

// File: tb/tb_seq_rec_pattern_shft_reg.sv
// Bench for seq_rec_pattern_shft_reg: six configurations share one stimulus stream and are
// checked against a history-value reference model, directed tables and corner sequences.
module tb_seq_rec_pattern_shft_reg;
    localparam int NI = 6;
`ifdef SEQ_REC_MATCH_CNT_EN
    localparam bit CNT_ON = 1'b1;
`else
    localparam bit CNT_ON = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic d_in = 1'b0;
    logic en = 1'b0;
    logic clr = 1'b0;

    always #5 clk = ~clk;

    seq_rec_pattern_shft_reg_if #(.CNT_W(8)) if0 ();
    seq_rec_pattern_shft_reg_if #(.CNT_W(8)) if1 ();
    seq_rec_pattern_shft_reg_if #(.CNT_W(2)) if2 ();
    seq_rec_pattern_shft_reg_if #(.CNT_W(2)) if3 ();
    seq_rec_pattern_shft_reg_if #(.CNT_W(8)) if4 ();
    seq_rec_pattern_shft_reg_if #(.CNT_W(2)) if5 ();

    assign if0.D_in = d_in; assign if0.En = en; assign if0.clr_cnt = clr;
    assign if1.D_in = d_in; assign if1.En = en; assign if1.clr_cnt = clr;
    assign if2.D_in = d_in; assign if2.En = en; assign if2.clr_cnt = clr;
    assign if3.D_in = d_in; assign if3.En = en; assign if3.clr_cnt = clr;
    assign if4.D_in = d_in; assign if4.En = en; assign if4.clr_cnt = clr;
    assign if5.D_in = d_in; assign if5.En = en; assign if5.clr_cnt = clr;

    seq_rec_pattern_shft_reg #(.N(3), .PATTERN(3'b111),  .MOORE(1'b0), .OVERLAP(1'b1), .CNT_W(8))
        u0 (.clk(clk), .reset(reset), .bus(if0));
    seq_rec_pattern_shft_reg #(.N(3), .PATTERN(3'b111),  .MOORE(1'b1), .OVERLAP(1'b1), .CNT_W(8))
        u1 (.clk(clk), .reset(reset), .bus(if1));
    seq_rec_pattern_shft_reg #(.N(4), .PATTERN(4'b1011), .MOORE(1'b0), .OVERLAP(1'b0), .CNT_W(2))
        u2 (.clk(clk), .reset(reset), .bus(if2));
    seq_rec_pattern_shft_reg #(.N(4), .PATTERN(4'b1011), .MOORE(1'b1), .OVERLAP(1'b0), .CNT_W(2))
        u3 (.clk(clk), .reset(reset), .bus(if3));
    seq_rec_pattern_shft_reg #(.N(3), .PATTERN(3'b000),  .MOORE(1'b0), .OVERLAP(1'b1), .CNT_W(8))
        u4 (.clk(clk), .reset(reset), .bus(if4));
    seq_rec_pattern_shft_reg #(.N(4), .PATTERN(4'b1011), .MOORE(1'b0), .OVERLAP(1'b1), .CNT_W(2))
        u5 (.clk(clk), .reset(reset), .bus(if5));

    logic        dout [NI];
    logic [15:0] cnt_act [NI];
    assign dout[0] = if0.D_out; assign cnt_act[0] = 16'(if0.match_cnt);
    assign dout[1] = if1.D_out; assign cnt_act[1] = 16'(if1.match_cnt);
    assign dout[2] = if2.D_out; assign cnt_act[2] = 16'(if2.match_cnt);
    assign dout[3] = if3.D_out; assign cnt_act[3] = 16'(if3.match_cnt);
    assign dout[4] = if4.D_out; assign cnt_act[4] = 16'(if4.match_cnt);
    assign dout[5] = if5.D_out; assign cnt_act[5] = 16'(if5.match_cnt);

    int cfg_n     [NI] = '{3, 3, 4, 4, 3, 4};
    int cfg_pat   [NI] = '{7, 7, 11, 11, 0, 11};
    bit cfg_moore [NI] = '{0, 1, 0, 1, 0, 0};
    bit cfg_ovl   [NI] = '{1, 1, 0, 0, 1, 1};
    int cfg_cw    [NI] = '{8, 8, 2, 2, 8, 2};

    // Model: integer value of the bits held since the last discard, plus a count of them.
    int m_hist [NI];
    int m_len  [NI];
    int m_cnt  [NI];
    int hits   [NI];

    int tests = 0;
    int fails = 0;
    int txn   = 0;

    function automatic bit exp_dout(int i);
        int m;
        m = 1 << cfg_n[i];
        if (cfg_moore[i])
            return (m_len[i] == cfg_n[i]) && (m_hist[i] == cfg_pat[i]);
        return (en == 1'b1) && (m_len[i] >= cfg_n[i] - 1) &&
               (((m_hist[i] * 2 + int'(d_in)) % m) == cfg_pat[i]);
    endfunction

    function automatic int exp_cnt(int i);
        return CNT_ON ? m_cnt[i] : 0;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NI; i++) begin
            m_hist[i] = 0; m_len[i] = 0; m_cnt[i] = 0; hits[i] = 0;
        end
    endtask

    task automatic model_edge();
        for (int i = 0; i < NI; i++) begin
            bit hit;
            bit now_hit;
            int m;
            hit = 1'b0;
            m = 1 << cfg_n[i];
            if (en) begin
                now_hit = exp_dout(i);
                if (!cfg_moore[i]) begin
                    hit = now_hit;
                    if (hit && !cfg_ovl[i]) begin
                        m_hist[i] = 0; m_len[i] = 0;
                    end else begin
                        m_hist[i] = (m_hist[i] * 2 + int'(d_in)) % m;
                        m_len[i]  = (m_len[i] < cfg_n[i]) ? m_len[i] + 1 : cfg_n[i];
                    end
                end else begin
                    if (!cfg_ovl[i] && now_hit) begin
                        m_hist[i] = int'(d_in); m_len[i] = 1;
                    end else begin
                        m_hist[i] = (m_hist[i] * 2 + int'(d_in)) % m;
                        m_len[i]  = (m_len[i] < cfg_n[i]) ? m_len[i] + 1 : cfg_n[i];
                    end
                    hit = (m_len[i] == cfg_n[i]) && (m_hist[i] == cfg_pat[i]);
                end
            end
            if (clr) m_cnt[i] = 0;
            else if (hit && m_cnt[i] < (1 << cfg_w(i)) - 1) m_cnt[i]++;
        end
    endtask

    function automatic int cfg_w(int i);
        return cfg_cw[i];
    endfunction

    task automatic check_all();
        txn++;
        $display("[TB] txn %0d rst=%b d=%b en=%b clr=%b dout=%b%b%b%b%b%b cnt=%0d/%0d/%0d/%0d/%0d/%0d",
                 txn, reset, d_in, en, clr, dout[0], dout[1], dout[2], dout[3], dout[4], dout[5],
                 cnt_act[0], cnt_act[1], cnt_act[2], cnt_act[3], cnt_act[4], cnt_act[5]);
        for (int i = 0; i < NI; i++) begin
            tests++;
            if (dout[i] !== exp_dout(i)) begin
                fails++;
                $display("[TB] FAIL dout_u%0d txn %0d: got %b expected %b", i, txn, dout[i], exp_dout(i));
            end
            tests++;
            if (cnt_act[i] !== 16'(exp_cnt(i))) begin
                fails++;
                $display("[TB] FAIL cnt_u%0d txn %0d: got %0d expected %0d", i, txn, cnt_act[i], exp_cnt(i));
            end
            if (dout[i] === 1'b1 && !cfg_moore[i]) hits[i]++;
        end
    endtask

    task automatic drive_check(input bit d, input bit e, input bit c);
        @(posedge clk);
        #1;
        d_in = d; en = e; clr = c;
        #1;
        check_all();
    endtask

    task automatic finish_edge();
        @(negedge clk);
        model_edge();
    endtask

    task automatic step(input bit d, input bit e, input bit c);
        drive_check(d, e, c);
        finish_edge();
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        reset = 1'b0; en = 1'b0; clr = 1'b0;
        model_reset();
        #1;
        check_all();
        @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    task automatic expect_val(input string name, input int got, input int want);
        tests++;
        if (got != want) begin
            fails++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, got, want);
        end
    endtask

    typedef struct {
        bit d;
        bit en;
        bit exp_mealy;
        bit exp_moore;
    } vec_t;

    vec_t tbl [7];

    initial begin
        tbl[0] = '{d: 1'b0, en: 1'b1, exp_mealy: 1'b0, exp_moore: 1'b0};
        tbl[1] = '{d: 1'b1, en: 1'b1, exp_mealy: 1'b0, exp_moore: 1'b0};
        tbl[2] = '{d: 1'b1, en: 1'b1, exp_mealy: 1'b0, exp_moore: 1'b0};
        tbl[3] = '{d: 1'b1, en: 1'b1, exp_mealy: 1'b1, exp_moore: 1'b0};
        tbl[4] = '{d: 1'b1, en: 1'b1, exp_mealy: 1'b1, exp_moore: 1'b1};
        tbl[5] = '{d: 1'b0, en: 1'b1, exp_mealy: 1'b0, exp_moore: 1'b1};
        tbl[6] = '{d: 1'b0, en: 1'b0, exp_mealy: 1'b0, exp_moore: 1'b0};

        model_reset();
        do_reset();

        // Three-1s stream for the Mealy (u0) and Moore (u1) instances.
        for (int k = 0; k < 7; k++) begin
            drive_check(tbl[k].d, tbl[k].en, 1'b0);
            expect_val($sformatf("tbl_mealy_bit%0d", k), int'(dout[0]), int'(tbl[k].exp_mealy));
            expect_val($sformatf("tbl_moore_bit%0d", k), int'(dout[1]), int'(tbl[k].exp_moore));
            finish_edge();
        end
        expect_val("tbl_mealy_cnt", int'(cnt_act[0]), CNT_ON ? 2 : 0);
        expect_val("tbl_moore_cnt", int'(cnt_act[1]), CNT_ON ? 2 : 0);

        // 1011 with and without overlap.
        do_reset();
        step(1, 1, 0); step(0, 1, 0); step(1, 1, 0); step(1, 1, 0);
        step(0, 1, 0); step(1, 1, 0); step(1, 1, 0);
        drive_check(0, 0, 0);
        finish_edge();
        expect_val("ovl_mealy_hits", hits[5], 2);
        expect_val("novl_mealy_hits", hits[2], 1);
        expect_val("ovl_cnt", int'(cnt_act[5]), CNT_ON ? 2 : 0);
        expect_val("novl_cnt", int'(cnt_act[2]), CNT_ON ? 1 : 0);

        // Zero pattern right after reset: fill guard holds off the first two bits.
        do_reset();
        drive_check(0, 1, 0); expect_val("zero_pat_bit1", int'(dout[4]), 0); finish_edge();
        drive_check(0, 1, 0); expect_val("zero_pat_bit2", int'(dout[4]), 0); finish_edge();
        drive_check(0, 1, 0); expect_val("zero_pat_bit3", int'(dout[4]), 1); finish_edge();

        // Enable gap inside a pattern, then a reset inside a pattern.
        do_reset();
        step(1, 1, 0); step(1, 1, 0);
        for (int k = 0; k < 5; k++) step(1, 0, 0);
        step(1, 1, 0);
        expect_val("en_gap_hits", hits[0], 1);
        do_reset();
        step(1, 1, 0); step(1, 1, 0);
        do_reset();
        step(1, 1, 0);
        expect_val("mid_reset_hits", hits[0], 0);

        // Saturation of the 2-bit counter, then clear on a match edge.
        do_reset();
        step(1, 1, 0); step(0, 1, 0); step(1, 1, 0); step(1, 1, 0);
        for (int k = 0; k < 4; k++) begin
            step(0, 1, 0); step(1, 1, 0); step(1, 1, 0);
        end
        drive_check(0, 0, 0); finish_edge();
        expect_val("sat_cnt", int'(cnt_act[5]), CNT_ON ? 3 : 0);
        step(0, 1, 0); step(1, 1, 0);
        drive_check(1, 1, 1);
        expect_val("clr_edge_match", int'(dout[5]), 1);
        finish_edge();
        drive_check(0, 0, 0); finish_edge();
        expect_val("clr_wins_cnt", int'(cnt_act[5]), 0);

        // Randomized run against the model.
        for (int k = 0; k < 400; k++) begin
            if ($urandom_range(99) < 2) begin
                do_reset();
            end else begin
                step(bit'($urandom_range(99) < 65), bit'($urandom_range(99) < 80),
                     bit'($urandom_range(99) < 4));
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
